// File: rtl/or_8bit_arbiter_if.sv
// rtl/or_8bit_arbiter_if.sv - requester/consumer bundle for the OR arbiter
//
// Purpose: groups the per-requester operand channels and the shared result
// channel of or_8bit_arbiter.
// Signals:
//   req_valid [N_REQ]        per-requester operand valid
//   req_ready [N_REQ]        per-requester accept, one-hot or zero
//   req_a/req_b [N_REQ*WIDTH] operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready      result handshake
//   rsp_data [WIDTH]         registered a | b of the granted requester
//   rsp_id [ID_W]            index of the granted requester
//   busy                     high while a result is pending
// Modports: master = requesters + consumer, slave = arbiter.
interface or_8bit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/or_8bit_arbiter.sv
// rtl/or_8bit_arbiter.sv - round-robin arbiter sharing one registered OR datapath
//
// Purpose: grants one of N_REQ requesters per transaction, registers
// a | b of its operands and returns it with the requester index.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  or_8bit_arbiter_if.slave (request channels, response channel, busy)
module or_8bit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  or_8bit_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [N_REQ-1:0]  ready_d;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   cand;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ready_d     = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    cand        = '0;

    // Scan starts one past the last grant so the previous winner goes last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          ready_d[sel_idx] = 1'b1;
          rsp_data_d  = bus.req_a[sel_idx*WIDTH +: WIDTH] | bus.req_b[sel_idx*WIDTH +: WIDTH];
          rsp_id_d    = sel_idx;
          ptr_d       = sel_idx;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Grants are suppressed while reset is held so nothing is handed out that
  // the registers would then ignore.
  assign bus.req_ready = rst ? '0 : ready_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q == RESP);

endmodule

// File: doc/or_8bit_arbiter.md
Name: or_8bit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 8-bit bitwise-OR datapath between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per transaction, computes y = a | b, and returns the result with the requester ID on a single valid/ready response channel. It sits between the requester-side logic and the downstream result consumer.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits
ID_W, 2, width of rsp_id; must equal ceil(log2(N_REQ))

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester operand-valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_a  input  N_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  operand b; same packing as req_a
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_data  output  WIDTH  registered a | b of the granted requester
rsp_id  output  ID_W  index of the granted requester
busy  output  1  high while in RESP state

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- State machine has two states, IDLE and RESP.
- Reset values: state=IDLE, ptr=N_REQ-1, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, req_ready=0.
- Requester 0 has the highest priority on the first grant after reset.
- IDLE arbitration:
  - Scan requesters ptr+1, ptr+2, ... modulo N_REQ.
  - The first i with req_valid[i]=1 is selected.
  - req_ready[i] is driven combinationally high in the same cycle. All other req_ready bits are 0.
  - No valid requester: req_ready=0 and the block stays in IDLE.
- Accept edge (req_valid[i] & req_ready[i]):
  - rsp_data <= req_a[i] | req_b[i].
  - rsp_id <= i.
  - ptr <= i.
  - rsp_valid <= 1; state <= RESP.
- RESP:
  - req_ready=0 for all requesters.
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On that edge: rsp_valid <= 0, state <= IDLE.
  - rsp_data and rsp_id keep their last values after the handshake.
- Latency and throughput:
  - Accept to rsp_valid is 1 cycle.
  - Best case is one transaction every 2 cycles. There is no accept in the same cycle as a response handshake.
- Fairness:
  - The pointer always advances to the last granted index.
  - With all N_REQ requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,...
  - A waiting requester is granted within N_REQ transactions.
- Protocol assumptions on requesters:
  - A requester holds req_valid and its operands stable until accepted.
  - Deasserting req_valid before accept is allowed. The arbiter then simply skips that requester.
- Wrap-around: ptr=N_REQ-1 wraps so that the scan starts at 0.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation: rst during RESP drops rsp_valid on the next edge, returns to IDLE, clears rsp_data/rsp_id and restores ptr=N_REQ-1. The pending result is discarded.
- Arithmetic: bitwise OR over WIDTH bits; no carry and no sign handling.

Test Plan:
- Single requester, no contention:
  - Stimulus: reset, then req_valid=0001 with a0=00011100, b0=00010001, rsp_ready=1.
  - Required: req_ready=0001 in the accept cycle; next cycle rsp_valid=1, rsp_data=00011101, rsp_id=0; then back to IDLE.
- Backpressure:
  - Stimulus: requester 2 with a2=10110010, b2=11110100; rsp_ready=0 for 5 cycles.
  - Required: rsp_data=11110110 and rsp_id=2 held stable for all 5 cycles; busy=1; req_ready=0000 throughout.
  - After rsp_ready=1: one-cycle handshake, then IDLE.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously with distinct operands, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0,1; a new accept every 2 cycles; each rsp_data equals the matching a|b.
- Pointer wrap and skip:
  - Stimulus: after a grant to 3, assert only requesters 1 and 3.
  - Required: next grant is 1, then 3.
- Reset mid-transaction:
  - Stimulus: assert rst while in RESP with rsp_ready=0.
  - Required: next cycle rsp_valid=0, rsp_data=0, busy=0; the first grant after reset goes to the lowest-index valid requester.
- Edge operands:
  - Stimulus: a=00000000, b=00000000, then a=11111111, b=00000000.
  - Required: rsp_data=00000000, then 11111111.
